// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and field positions.
// Optional timer registers are enabled with CP0_TIMER_EN.
package cp0_exc_unit_pkg;

    typedef enum logic [4:0] {
        RegCount   = 5'd9,
        RegCompare = 5'd11,
        RegSr      = 5'd12,
        RegCause   = 5'd13,
        RegEpc     = 5'd14,
        RegPrid    = 5'd15
    } cp0_reg_e;

    typedef enum logic [4:0] {
        ExcInt  = 5'd0,
        ExcAdEL = 5'd4,
        ExcAdES = 5'd5,
        ExcRi   = 5'd10,
        ExcOv   = 5'd12
    } exc_code_e;

    localparam int unsigned ImLsb      = 10;
    localparam int unsigned ImMsb      = 15;
    localparam int unsigned SrExlBit   = 1;
    localparam int unsigned SrIeBit    = 0;
    localparam int unsigned CauseBdBit = 31;
    localparam int unsigned ExcLsb     = 2;
    localparam int unsigned ExcMsb     = 6;

    // Word address of the restart point: a delay-slot instruction restarts at its branch.
    function automatic logic [29:0] epc_target(input logic [29:0] pc_word, input logic bd);
        return bd ? (pc_word - 30'd1) : pc_word;
    endfunction

endpackage

// File: rtl/cp0_exc_unit_if.sv
// M-stage bus between the pipeline and the CP0 exception unit.
// Shared by both default and CP0_TIMER_EN builds.
interface cp0_exc_unit_if;
    logic        we;
    logic [4:0]  addr_r;
    logic [4:0]  addr_w;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;

    modport master (
        output we, addr_r, addr_w, din, pc_m, bd_m, exc_code_in, hw_int, eret,
        input  dout, req, handler_pc, epc_out
    );

    modport slave (
        input  we, addr_r, addr_w, din, pc_m, bd_m, exc_code_in, hw_int, eret,
        output dout, req, handler_pc, epc_out
    );
endinterface

// File: rtl/cp0_exc_unit_timer.sv
// Count/Compare timer with sticky match flag; only built when CP0_TIMER_EN is defined.
`ifdef CP0_TIMER_EN
module cp0_exc_unit_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wr_count,
    input  logic        i_wr_compare,
    input  logic [31:0] i_din,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_pend
);
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_compare <= '0;
            r_pend    <= 1'b0;
        end else begin
            r_count <= i_wr_count ? i_din : (r_count + 32'd1);
            if (i_wr_compare) begin
                r_compare <= i_din;
                r_pend    <= 1'b0;
            end else if (r_count == r_compare) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_pend    = r_pend;
endmodule
`endif

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt unit: SR, Cause, EPC, PRId and the M-stage flush request.
// Define CP0_TIMER_EN to add Count/Compare and the timer interrupt on IP[15].
module cp0_exc_unit #(
    parameter logic [31:0] PRID_VAL   = 32'h0000_2019,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input logic           clk,
    input logic           reset,
    cp0_exc_unit_if.slave bus
);
    import cp0_exc_unit_pkg::*;

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc;
    logic [31:2] r_epc;

    logic [5:0]  w_int_src;
    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic        w_wr;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic [31:0] w_dout;
    logic [1:0]  w_unused_pc;

    assign w_unused_pc = bus.pc_m[1:0];

    // A taken exception or an eret owns the edge, so a coincident mtc0 is dropped.
    assign w_wr = bus.we & ~w_req & ~bus.eret;

`ifdef CP0_TIMER_EN
    logic w_timer_pend;

    cp0_exc_unit_timer u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_wr_count   (w_wr && (bus.addr_w == RegCount)),
        .i_wr_compare (w_wr && (bus.addr_w == RegCompare)),
        .i_din        (bus.din),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_pend       (w_timer_pend)
    );

    assign w_int_src = {bus.hw_int[5] | w_timer_pend, bus.hw_int[4:0]};
`else
    assign w_count   = '0;
    assign w_compare = '0;
    assign w_int_src = bus.hw_int;
`endif

    assign w_int_req = r_ie & ~r_exl & (|(w_int_src & r_im));
    assign w_exc_req = ~r_exl & (bus.exc_code_in != 5'd0);
    assign w_req     = ~reset & (w_int_req | w_exc_req);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im  <= '0;
            r_exl <= 1'b0;
            r_ie  <= 1'b0;
            r_bd  <= 1'b0;
            r_ip  <= '0;
            r_exc <= '0;
            r_epc <= '0;
        end else begin
            r_ip <= w_int_src;
            if (w_req) begin
                r_exl <= 1'b1;
                r_bd  <= bus.bd_m;
                r_exc <= w_int_req ? 5'(ExcInt) : bus.exc_code_in;
                r_epc <= epc_target(bus.pc_m[31:2], bus.bd_m);
            end else if (bus.eret) begin
                r_exl <= 1'b0;
            end else if (w_wr) begin
                case (bus.addr_w)
                    RegSr: begin
                        r_im  <= bus.din[ImMsb:ImLsb];
                        r_exl <= bus.din[SrExlBit];
                        r_ie  <= bus.din[SrIeBit];
                    end
                    RegEpc:  r_epc <= bus.din[31:2];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_dout = '0;
        case (bus.addr_r)
            RegSr: begin
                w_dout[ImMsb:ImLsb] = r_im;
                w_dout[SrExlBit]    = r_exl;
                w_dout[SrIeBit]     = r_ie;
            end
            RegCause: begin
                w_dout[CauseBdBit]    = r_bd;
                w_dout[ImMsb:ImLsb]   = r_ip;
                w_dout[ExcMsb:ExcLsb] = r_exc;
            end
            RegEpc:     w_dout = {r_epc, 2'b00};
            RegPrid:    w_dout = PRID_VAL;
            RegCount:   w_dout = w_count;
            RegCompare: w_dout = w_compare;
            default:    ;
        endcase
    end

    assign bus.dout       = w_dout;
    assign bus.req        = w_req;
    assign bus.handler_pc = HANDLER_PC;
    assign bus.epc_out    = {r_epc, 2'b00};
endmodule
